// File: rtl/apb_master_arb_if.sv
// Bundles the requester-side command/response signals and the APB master
// bus of apb_master_arb. The arbiter connects through the master modport;
// the requester fabric / APB slave side (or a bench) uses the slave modport.
interface apb_master_arb_if #(
    parameter int N_REQ = 2,
    parameter int ADDR  = 32,
    parameter int DATA  = 32
);
    localparam int STRB = DATA / 8;

    // requester side
    logic [N_REQ-1:0]      req_valid;
    logic [N_REQ-1:0]      req_write;
    logic [N_REQ*ADDR-1:0] req_addr;
    logic [N_REQ*DATA-1:0] req_wdata;
    logic [N_REQ*STRB-1:0] req_strb;
    logic [N_REQ-1:0]      req_ready;
    logic [N_REQ-1:0]      rsp_valid;
    logic [DATA-1:0]       rsp_rdata;
    logic                  rsp_err;
    logic                  rsp_timeout;

    // APB side
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR-1:0]       paddr;
    logic [DATA-1:0]       pwdata;
    logic [STRB-1:0]       pstrb;
    logic [DATA-1:0]       prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, req_strb,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output psel, penable, pwrite, paddr, pwdata, pstrb,
        input  prdata, pready, pslverr
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, req_strb,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  psel, penable, pwrite, paddr, pwdata, pstrb,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_master_arb.sv
// Round-robin arbiter that shares one APB master port among N_REQ requesters.
// One command is in flight at a time; the response (read data, slave error,
// timeout) is returned as a one-cycle pulse to the requester that owned it.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | no transfer; grant the next valid requester (round-robin)
// SETUP  | APB setup phase: psel=1, penable=0
// ACCESS | APB access phase: psel=penable=1, wait for pready or timeout
module apb_master_arb #(
    parameter int N_REQ   = 2,
    parameter int ADDR    = 32,
    parameter int DATA    = 32,
    parameter int TIMEOUT = 256
) (
    input  logic              clk,
    input  logic              reset,
    apb_master_arb_if.master  bus
);
    localparam int STRB = DATA / 8;
    localparam int RW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    // The counter only has to reach TIMEOUT-1: the cycle that would make it
    // TIMEOUT is the abort cycle itself.
    localparam int TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [RW-1:0]    rr_q, rr_d;
    logic [RW-1:0]    owner_q, owner_d;
    logic             write_q, write_d;
    logic [ADDR-1:0]  addr_q, addr_d;
    logic [DATA-1:0]  wdata_q, wdata_d;
    logic [STRB-1:0]  strb_q, strb_d;
    logic [TW-1:0]    cnt_q, cnt_d;
    logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [DATA-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic             rsp_err_q, rsp_err_d;
    logic             rsp_to_q, rsp_to_d;

    logic             gnt_found;
    logic [RW-1:0]    gnt_idx;
    logic [RW-1:0]    cand_idx;
    logic [N_REQ-1:0] req_ready_c;
    logic             psel_c;
    logic             penable_c;

    // Round-robin pick: first valid requester at or after the pointer.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand_idx  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand_idx = RW'((int'(rr_q) + k) % N_REQ);
            if (!gnt_found && bus.req_valid[cand_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand_idx;
            end
        end
    end

    // Next-state, command capture, response formation and APB phase outputs.
    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        owner_d     = owner_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        strb_d      = strb_q;
        cnt_d       = cnt_q;
        rsp_valid_d = '0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        rsp_to_d    = 1'b0;
        req_ready_c = '0;
        psel_c      = 1'b0;
        penable_c   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (gnt_found) begin
                    req_ready_c[gnt_idx] = 1'b1;
                    owner_d = gnt_idx;
                    write_d = bus.req_write[gnt_idx];
                    addr_d  = bus.req_addr[int'(gnt_idx)*ADDR +: ADDR];
                    wdata_d = bus.req_wdata[int'(gnt_idx)*DATA +: DATA];
                    strb_d  = bus.req_strb[int'(gnt_idx)*STRB +: STRB];
                    rr_d    = RW'((int'(gnt_idx) + 1) % N_REQ);
                    state_d = S_SETUP;
                end
            end

            S_SETUP: begin
                psel_c  = 1'b1;
                state_d = S_ACCESS;
            end

            S_ACCESS: begin
                psel_c    = 1'b1;
                penable_c = 1'b1;
                // pready is checked first so a completion on the abort cycle
                // still counts as a normal transfer.
                if (bus.pready) begin
                    rsp_valid_d[owner_q] = 1'b1;
                    rsp_rdata_d = write_q ? '0 : bus.prdata;
                    rsp_err_d   = bus.pslverr;
                    cnt_d       = '0;
                    state_d     = S_IDLE;
                end else if (TIMEOUT != 0 && cnt_q == TO_LAST) begin
                    rsp_valid_d[owner_q] = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_to_d    = 1'b1;
                    cnt_d       = '0;
                    state_d     = S_IDLE;
                end else if (TIMEOUT != 0) begin
                    cnt_d = cnt_q + TW'(1);
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // State, command and response registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rr_q        <= '0;
            owner_q     <= '0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            strb_q      <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_to_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            owner_q     <= owner_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            strb_q      <= strb_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            rsp_to_q    <= rsp_to_d;
        end
    end

    // req_ready is gated by reset so no command is accepted while held in reset.
    assign bus.req_ready   = reset ? '0 : req_ready_c;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_timeout = rsp_to_q;

    assign bus.psel    = psel_c;
    assign bus.penable = penable_c;
    assign bus.pwrite  = write_q;
    assign bus.paddr   = addr_q;
    assign bus.pwdata  = wdata_q;
    assign bus.pstrb   = write_q ? strb_q : '0;
endmodule

// File: doc/apb_master_arb.md
Name: apb_master_arb

Overview:
- Shares one APB master port among N_REQ internal requesters (DMA channel register paths, debug access).
- Accepts one command at a time under round-robin arbitration and sequences the APB SETUP/ACCESS phases.
- Handles wait states and PSLVERR, aborts hung transfers on timeout, and returns the response to the granted requester.
- Sits between the requester fabric and the APB bus; address/data widths follow the project-wide APB widths.

Parameters:
N_REQ, 2, number of requesters (1..8)
ADDR, 32, APB address width (project-wide max PADDR)
DATA, 32, APB data width (project-wide max PDATA); strobe width DATA/8
TIMEOUT, 256, max ACCESS cycles waiting for pready before abort; 0 disables timeout

Ports:
clk  input  1  single clock for all logic
reset  input  1  asynchronous active-high reset
req_valid  input  N_REQ  per-requester command valid, held until req_ready
req_write  input  N_REQ  per-requester 1=write, 0=read
req_addr  input  N_REQ*ADDR  per-requester address, slice i = requester i
req_wdata  input  N_REQ*DATA  per-requester write data
req_strb  input  N_REQ*(DATA/8)  per-requester write strobes
req_ready  output  N_REQ  one-hot accept pulse; command captured this cycle
rsp_valid  output  N_REQ  one-hot, one-cycle response pulse to the owning requester
rsp_rdata  output  DATA  read data, valid with rsp_valid; shared across requesters
rsp_err  output  1  1 = PSLVERR or timeout, valid with rsp_valid
rsp_timeout  output  1  1 = transfer aborted by timeout, valid with rsp_valid
psel  output  1  APB select
penable  output  1  APB enable
pwrite  output  1  APB direction
paddr  output  ADDR  APB address
pwdata  output  DATA  APB write data
pstrb  output  DATA/8  APB strobes; forced 0 on reads
prdata  input  DATA  APB read data
pready  input  1  APB ready
pslverr  input  1  APB slave error

Behaviour:
- FSM states IDLE, SETUP, ACCESS. Reset: state=IDLE, rr pointer=0, all outputs 0, timeout counter 0.
- req_ready is combinational: nonzero only in IDLE, with at most one bit set.
- IDLE:
  - If any req_valid, grant the first valid index at or after rr pointer, wrapping modulo N_REQ.
  - Assert req_ready[g] that cycle and register write/addr/wdata/strb and owner g.
  - Set rr pointer = (g+1) mod N_REQ. Next state SETUP.
  - With no valid requests, stay in IDLE and hold the pointer.
- SETUP: psel=1, penable=0, paddr/pwrite/pwdata/pstrb driven from registers. Unconditionally go to ACCESS next cycle.
- ACCESS:
  - psel=1, penable=1; address, control and data held stable.
  - On pready=1: next cycle rsp_valid[owner]=1 for one cycle, rsp_rdata=registered prdata (0 for writes), rsp_err=registered pslverr, rsp_timeout=0. Return to IDLE with psel=penable=0.
  - The timeout counter increments each ACCESS cycle with pready=0. If TIMEOUT!=0 and the counter reaches TIMEOUT, abort: psel=penable=0, rsp_valid[owner], rsp_err=1, rsp_timeout=1, rsp_rdata=0, go to IDLE. The counter clears on leaving ACCESS.
  - pready and timeout in the same cycle: pready wins (normal completion).
- Minimum transfer: grant cycle + SETUP + ACCESS + response = psel high 2 cycles; the next grant occurs in the response cycle at the earliest.
- pslverr and prdata are sampled only when psel&penable&pready. pstrb=0 whenever pwrite=0.
- Requesters must not drop req_valid before req_ready. If one does, the command is simply not granted; the arbiter makes no ordering promise for it.
- N_REQ=1: the pointer is a constant 0 and the arbiter degenerates to a pass-through sequencer.
- Reset asserted mid-transfer: outputs clear asynchronously and no rsp_valid is issued for the aborted transfer.

Test Plan:
- Single write: req 0 write addr=0x10 data=0xA5A5A5A5 strb=0xF, pready=1 immediately -> req_ready[0] pulse, psel 2 cycles (penable in the 2nd), rsp_valid[0] with rsp_err=0 one cycle later.
- Read with 3 wait states: pready low 3 ACCESS cycles then high with prdata=0x12345678 -> ACCESS lasts 4 cycles, paddr stable throughout, rsp_rdata=0x12345678, rsp_valid[0].
- Round-robin: both requesters valid continuously for 4 transfers -> grant order 0,1,0,1. Only requester 1 valid after reset -> grant 1 with no extra latency.
- Slave error: pslverr=1 with pready -> rsp_err=1, rsp_timeout=0. Read transfer -> pstrb=0.
- Timeout: TIMEOUT=4, pready held low -> abort after 4 ACCESS cycles, psel drops, rsp_err=1, rsp_timeout=1. pready and timeout in the same cycle -> normal completion.
- Reset during ACCESS -> psel/penable/rsp_valid 0 immediately; after release, the next request is granted starting with requester 0.
